// File: rtl/pc8_sequencer_if.sv
// Control/status bundle between the pc8 sequencer and the rest of the CPU.
// The master side owns the instruction-memory and flag inputs. The slave side
// is the sequencer, which drives the PC, IR and register-file strobes.
interface pc8_sequencer_if;
    logic       START;
    logic       STALL;
    logic [7:0] INSTR;
    logic       ZF;
    logic       INC;
    logic       LOAD;
    logic [7:0] LOAD_ADDR;
    logic       IR_WE;
    logic       REG_WE;
    logic [7:0] RETIRED;
    logic [2:0] STATE;
    logic       HALTED;

    modport master (
        output START,
        output STALL,
        output INSTR,
        output ZF,
        input  INC,
        input  LOAD,
        input  LOAD_ADDR,
        input  IR_WE,
        input  REG_WE,
        input  RETIRED,
        input  STATE,
        input  HALTED
    );

    modport slave (
        input  START,
        input  STALL,
        input  INSTR,
        input  ZF,
        output INC,
        output LOAD,
        output LOAD_ADDR,
        output IR_WE,
        output REG_WE,
        output RETIRED,
        output STATE,
        output HALTED
    );
endinterface

// File: rtl/pc8_sequencer.sv
// Fetch/decode/execute control FSM for the 8-bit CPU.
// It steps the PC (INC or LOAD), strobes the IR and the register file, and
// counts retired instructions. HLT is not counted as a retired instruction.
module pc8_sequencer #(
    parameter logic [3:0] JMP_OPC     = 4'h8,
    parameter logic [3:0] JZ_OPC      = 4'h9,
    parameter logic [3:0] HLT_OPC     = 4'hF,
    parameter logic [3:0] ALU_OPC_MAX = 4'h7
) (
    input  logic           CLK,
    input  logic           RST,
    pc8_sequencer_if.slave bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_OPER   = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic [3:0] opcode_reg;
    logic [3:0] opcode_next;
    logic [7:0] retired_reg;
    logic [7:0] retired_next;

    logic       is_alu_op;
    logic       jump_taken;

    // Opcodes 1..ALU_OPC_MAX write the register file. Everything else that
    // reaches EXEC (0, ALU_OPC_MAX+1..7, unlisted 8..E) behaves as a NOP.
    assign is_alu_op  = (opcode_reg != 4'h0) && (opcode_reg <= ALU_OPC_MAX);

    // OPER is only entered for JMP or JZ, so JMP or (JZ and ZF) means taken.
    assign jump_taken = (opcode_reg == JMP_OPC) ||
                        ((opcode_reg == JZ_OPC) && bus.ZF);

    // State, opcode and retired-count registers. Reset overrides all inputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            opcode_reg  <= 4'h0;
            retired_reg <= 8'h00;
        end else begin
            state_reg   <= state_next;
            opcode_reg  <= opcode_next;
            retired_reg <= retired_next;
        end
    end

    // Next-state decode, plus the next values of the opcode and retired count.
    always_comb begin
        state_next   = state_reg;
        opcode_next  = opcode_reg;
        retired_next = retired_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.START) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // A stalled fetch holds here until memory presents the byte.
                if (!bus.STALL) begin
                    opcode_next = bus.INSTR[7:4];
                    state_next  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (opcode_reg == HLT_OPC) begin
                    state_next = ST_HALT;
                end else if ((opcode_reg == JMP_OPC) || (opcode_reg == JZ_OPC)) begin
                    state_next = ST_OPER;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                retired_next = retired_reg + 8'd1;
                state_next   = ST_FETCH;
            end
            ST_OPER: begin
                // The operand byte is consumed only when memory is ready.
                if (!bus.STALL) begin
                    retired_next = retired_reg + 8'd1;
                    state_next   = ST_FETCH;
                end
            end
            ST_HALT: begin
                // START is ignored here; only reset leaves HALT.
                state_next = ST_HALT;
            end
            default: begin
                // Codes 6 and 7 are unreachable; recover to IDLE if they occur.
                state_next = ST_IDLE;
            end
        endcase
    end

    // Strobes and status outputs decoded from the current state and inputs.
    always_comb begin
        bus.INC       = 1'b0;
        bus.LOAD      = 1'b0;
        bus.LOAD_ADDR = 8'h00;
        bus.IR_WE     = 1'b0;
        bus.REG_WE    = 1'b0;
        bus.RETIRED   = retired_reg;
        bus.STATE     = state_reg;
        bus.HALTED    = (state_reg == ST_HALT);
        case (state_reg)
            ST_FETCH: begin
                if (!bus.STALL) begin
                    bus.IR_WE = 1'b1;
                    bus.INC   = 1'b1;
                end
            end
            ST_EXEC: begin
                bus.REG_WE = is_alu_op;
            end
            ST_OPER: begin
                if (!bus.STALL) begin
                    if (jump_taken) begin
                        bus.LOAD      = 1'b1;
                        bus.LOAD_ADDR = bus.INSTR;
                    end else begin
                        // Not-taken JZ steps the PC past its operand byte.
                        bus.INC = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pc8_sequencer.sv
// Scoreboard bench for pc8_sequencer. The stimulus process drives one vector
// per cycle and queues the hand-computed outputs expected for that cycle.
// The monitor pops one entry on each falling edge and compares it.
module tb_pc8_sequencer;

    typedef struct packed {
        logic [2:0] st;
        logic       inc;
        logic       load;
        logic [7:0] la;
        logic       ir_we;
        logic       reg_we;
        logic [7:0] ret;
        logic       halted;
    } exp_t;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FET  = 3'd1;
    localparam logic [2:0] S_DEC  = 3'd2;
    localparam logic [2:0] S_EXE  = 3'd3;
    localparam logic [2:0] S_OPR  = 3'd4;
    localparam logic [2:0] S_HLT  = 3'd5;

    logic clk;
    logic rst;
    logic armed;
    int   phase;
    int   total;
    int   bad;
    exp_t exp_q[$];
    int   tag_q[$];

    pc8_sequencer_if bus ();

    pc8_sequencer dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ex(input logic [2:0] st, input logic inc, input logic load,
                                input logic [7:0] la, input logic ir, input logic rw,
                                input logic [7:0] ret, input logic h);
        exp_t e;
        e.st = st; e.inc = inc; e.load = load; e.la = la;
        e.ir_we = ir; e.reg_we = rw; e.ret = ret; e.halted = h;
        return e;
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected while those inputs are applied.
    task automatic cyc(input logic r, input logic s, input logic stl, input logic [7:0] ins,
                       input logic z, input logic chk, input exp_t e);
        @(posedge clk);
        #1;
        rst       = r;
        bus.START = s;
        bus.STALL = stl;
        bus.INSTR = ins;
        bus.ZF    = z;
        if (chk) begin
            exp_q.push_back(e);
            tag_q.push_back(phase);
        end
    endtask

    // Monitor: scoreboard comparison plus the INC/LOAD/LOAD_ADDR invariants.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        int   t;
        if (armed) begin
            total = total + 1;
            if ((bus.INC && bus.LOAD) || (!bus.LOAD && bus.LOAD_ADDR != 8'h00)) begin
                bad = bad + 1;
                $display("FAIL invariant phase%0d: inc=%0b load=%0b load_addr=%h (required inc&load=0, load_addr=00 when load=0)",
                         phase, bus.INC, bus.LOAD, bus.LOAD_ADDR);
            end
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = ex(bus.STATE, bus.INC, bus.LOAD, bus.LOAD_ADDR, bus.IR_WE,
                   bus.REG_WE, bus.RETIRED, bus.HALTED);
            total = total + 1;
            if (a !== e) begin
                bad = bad + 1;
                $display("FAIL phase%0d: got st=%0d inc=%0b ld=%0b la=%h ir=%0b rw=%0b ret=%h hlt=%0b, required st=%0d inc=%0b ld=%0b la=%h ir=%0b rw=%0b ret=%h hlt=%0b",
                         t, a.st, a.inc, a.load, a.la, a.ir_we, a.reg_we, a.ret, a.halted,
                         e.st, e.inc, e.load, e.la, e.ir_we, e.reg_we, e.ret, e.halted);
            end else begin
                $display("ok phase%0d: st=%0d inc=%0b ld=%0b la=%h ir=%0b rw=%0b ret=%h hlt=%0b",
                         t, a.st, a.inc, a.load, a.la, a.ir_we, a.reg_we, a.ret, a.halted);
            end
        end
    end

    initial begin
        logic [7:0] r;
        total = 0;
        bad   = 0;
        armed = 1'b0;
        phase = 0;
        rst       = 1'b1;
        bus.START = 1'b0;
        bus.STALL = 1'b0;
        bus.INSTR = 8'h00;
        bus.ZF    = 1'b0;

        // Phase 1: reset for two cycles, then idle with START=0.
        phase = 1;
        cyc(1, 0, 0, 8'h00, 0, 0, ex(S_IDLE, 0, 0, 8'h00, 0, 0, 8'h00, 0));
        armed = 1'b1;
        cyc(1, 0, 0, 8'h00, 0, 1, ex(S_IDLE, 0, 0, 8'h00, 0, 0, 8'h00, 0));
        cyc(0, 0, 0, 8'h00, 0, 1, ex(S_IDLE, 0, 0, 8'h00, 0, 0, 8'h00, 0));

        // Phase 2: ALU op 8'h35.
        phase = 2;
        cyc(0, 1, 0, 8'h35, 0, 1, ex(S_IDLE, 0, 0, 8'h00, 0, 0, 8'h00, 0));
        cyc(0, 0, 0, 8'h35, 0, 1, ex(S_FET,  1, 0, 8'h00, 1, 0, 8'h00, 0));
        cyc(0, 0, 0, 8'h35, 0, 1, ex(S_DEC,  0, 0, 8'h00, 0, 0, 8'h00, 0));
        cyc(0, 0, 0, 8'h35, 0, 1, ex(S_EXE,  0, 0, 8'h00, 0, 1, 8'h00, 0));

        // Phase 3: FETCH stalled 3 cycles, JMP 8'h80, OPER stalled 2 cycles, operand 8'h42.
        phase = 3;
        cyc(0, 0, 1, 8'h80, 0, 1, ex(S_FET,  0, 0, 8'h00, 0, 0, 8'h01, 0));
        cyc(0, 0, 1, 8'h80, 0, 1, ex(S_FET,  0, 0, 8'h00, 0, 0, 8'h01, 0));
        cyc(0, 0, 1, 8'h80, 0, 1, ex(S_FET,  0, 0, 8'h00, 0, 0, 8'h01, 0));
        cyc(0, 0, 0, 8'h80, 0, 1, ex(S_FET,  1, 0, 8'h00, 1, 0, 8'h01, 0));
        cyc(0, 0, 0, 8'h42, 0, 1, ex(S_DEC,  0, 0, 8'h00, 0, 0, 8'h01, 0));
        cyc(0, 0, 1, 8'h42, 0, 1, ex(S_OPR,  0, 0, 8'h00, 0, 0, 8'h01, 0));
        cyc(0, 0, 1, 8'h42, 0, 1, ex(S_OPR,  0, 0, 8'h00, 0, 0, 8'h01, 0));
        cyc(0, 0, 0, 8'h42, 0, 1, ex(S_OPR,  0, 1, 8'h42, 0, 0, 8'h01, 0));

        // Phase 4: JZ 8'h90 / 8'h10 with ZF=0 -> not taken.
        phase = 4;
        cyc(0, 0, 0, 8'h90, 1, 1, ex(S_FET,  1, 0, 8'h00, 1, 0, 8'h02, 0));
        cyc(0, 0, 0, 8'h10, 1, 1, ex(S_DEC,  0, 0, 8'h00, 0, 0, 8'h02, 0));
        cyc(0, 0, 0, 8'h10, 0, 1, ex(S_OPR,  1, 0, 8'h00, 0, 0, 8'h02, 0));

        // Phase 5: JZ 8'h95 / 8'h7C with ZF=1 -> taken.
        phase = 5;
        cyc(0, 0, 0, 8'h95, 0, 1, ex(S_FET,  1, 0, 8'h00, 1, 0, 8'h03, 0));
        cyc(0, 0, 0, 8'h7C, 0, 1, ex(S_DEC,  0, 0, 8'h00, 0, 0, 8'h03, 0));
        cyc(0, 0, 0, 8'h7C, 1, 1, ex(S_OPR,  0, 1, 8'h7C, 0, 0, 8'h03, 0));

        // Phase 6: unlisted opcode 8'hA3 is a NOP; opcode 7 (ALU_OPC_MAX) writes.
        phase = 6;
        cyc(0, 0, 0, 8'hA3, 0, 1, ex(S_FET,  1, 0, 8'h00, 1, 0, 8'h04, 0));
        cyc(0, 0, 0, 8'hA3, 0, 1, ex(S_DEC,  0, 0, 8'h00, 0, 0, 8'h04, 0));
        cyc(0, 0, 0, 8'hA3, 0, 1, ex(S_EXE,  0, 0, 8'h00, 0, 0, 8'h04, 0));
        cyc(0, 0, 0, 8'h71, 0, 1, ex(S_FET,  1, 0, 8'h00, 1, 0, 8'h05, 0));
        cyc(0, 0, 0, 8'h71, 0, 1, ex(S_DEC,  0, 0, 8'h00, 0, 0, 8'h05, 0));
        cyc(0, 0, 0, 8'h71, 0, 1, ex(S_EXE,  0, 0, 8'h00, 0, 1, 8'h05, 0));

        // Phase 7: HLT, START toggled 10 cycles while halted, then reset.
        phase = 7;
        cyc(0, 0, 0, 8'hF0, 0, 1, ex(S_FET,  1, 0, 8'h00, 1, 0, 8'h06, 0));
        cyc(0, 1, 0, 8'hF0, 0, 1, ex(S_DEC,  0, 0, 8'h00, 0, 0, 8'h06, 0));
        for (int i = 0; i < 10; i++) begin
            cyc(0, logic'(i[0]), 0, 8'h80, 1, 1, ex(S_HLT, 0, 0, 8'h00, 0, 0, 8'h06, 1));
        end
        cyc(1, 1, 0, 8'h80, 1, 1, ex(S_HLT,  0, 0, 8'h00, 0, 0, 8'h06, 1));
        cyc(0, 0, 0, 8'h00, 0, 1, ex(S_IDLE, 0, 0, 8'h00, 0, 0, 8'h00, 0));

        // Phase 8: retire one ALU op, then assert reset while in OPER.
        phase = 8;
        cyc(0, 1, 0, 8'h12, 0, 1, ex(S_IDLE, 0, 0, 8'h00, 0, 0, 8'h00, 0));
        cyc(0, 0, 0, 8'h12, 0, 1, ex(S_FET,  1, 0, 8'h00, 1, 0, 8'h00, 0));
        cyc(0, 0, 0, 8'h12, 0, 1, ex(S_DEC,  0, 0, 8'h00, 0, 0, 8'h00, 0));
        cyc(0, 0, 0, 8'h12, 0, 1, ex(S_EXE,  0, 0, 8'h00, 0, 1, 8'h00, 0));
        cyc(0, 0, 0, 8'h80, 0, 1, ex(S_FET,  1, 0, 8'h00, 1, 0, 8'h01, 0));
        cyc(0, 0, 0, 8'h33, 0, 1, ex(S_DEC,  0, 0, 8'h00, 0, 0, 8'h01, 0));
        cyc(1, 0, 0, 8'h33, 0, 1, ex(S_OPR,  0, 1, 8'h33, 0, 0, 8'h01, 0));
        cyc(0, 0, 0, 8'h00, 0, 1, ex(S_IDLE, 0, 0, 8'h00, 0, 0, 8'h00, 0));

        // Phase 9: 256 NOPs; RETIRED climbs to 8'hFF and wraps to 8'h00.
        phase = 9;
        r = 8'h00;
        cyc(0, 1, 0, 8'h00, 0, 1, ex(S_IDLE, 0, 0, 8'h00, 0, 0, 8'h00, 0));
        for (int i = 0; i < 256; i++) begin
            cyc(0, 0, 0, 8'h00, 0, 1, ex(S_FET, 1, 0, 8'h00, 1, 0, r, 0));
            cyc(0, 0, 0, 8'h00, 0, 1, ex(S_DEC, 0, 0, 8'h00, 0, 0, r, 0));
            cyc(0, 0, 0, 8'h00, 0, 1, ex(S_EXE, 0, 0, 8'h00, 0, 0, r, 0));
            r = r + 8'd1;
        end
        cyc(0, 0, 1, 8'h00, 0, 1, ex(S_FET,  0, 0, 8'h00, 0, 0, 8'h00, 0));

        // Let the monitor consume the last queued entry.
        cyc(0, 0, 1, 8'h00, 0, 0, ex(S_FET,  0, 0, 8'h00, 0, 0, 8'h00, 0));
        armed = 1'b0;
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc8_sequencer.md
Name: pc8_sequencer

Overview:
Fetch/decode/execute control FSM for the 8-bit CPU. It drives the program counter: INC to advance, LOAD plus LOAD_ADDR for absolute jumps. It also drives the instruction register write and the register-file write strobe, and counts retired instructions. It sits between instruction ROM output, the PC, and the datapath write enables.

Parameters:
JMP_OPC, 4'h8, opcode of unconditional two-byte jump
JZ_OPC, 4'h9, opcode of two-byte jump-if-zero
HLT_OPC, 4'hF, opcode of halt
ALU_OPC_MAX, 4'h7, opcodes 4'h1..ALU_OPC_MAX are register-writing ops; 4'h0 is NOP

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  reset, synchronous, active-high
START  in  1  leave IDLE and begin fetching
STALL  in  1  instruction memory not ready; INSTR invalid this cycle
INSTR  in  8  byte from instruction memory at current PC
ZF  in  1  zero flag from ALU, sampled in OPER
INC  out  1  PC increment request (to PC INC)
LOAD  out  1  PC load request
LOAD_ADDR  out  8  PC load value, valid when LOAD=1
IR_WE  out  1  instruction register write strobe
REG_WE  out  1  register-file write strobe
RETIRED  out  8  retired-instruction counter
STATE  out  3  current state encoding
HALTED  out  1  1 while in HALT

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high. RST=1 at an edge forces IDLE, clears the opcode register and RETIRED=0, and overrides every other input, including mid-instruction and in HALT.
- After reset, all outputs are 0: INC, LOAD, LOAD_ADDR=8'h00, IR_WE, REG_WE, RETIRED=8'h00, STATE=3'd0, HALTED.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, OPER=4, HALT=5. Codes 6 and 7 are unreachable; if entered, go to IDLE next edge.
- Outputs are combinational from the state, STALL, INSTR, ZF and the opcode register. The state, opcode register and RETIRED are registers.
- IDLE: all strobes 0. START=1 -> FETCH; otherwise stay.
- FETCH with STALL=1: all strobes 0; stay.
- FETCH with STALL=0: IR_WE=1 and INC=1 in the same cycle. Opcode register <= INSTR[7:4]. Next state DECODE.
- DECODE: no strobes.
  - Opcode == HLT_OPC -> HALT.
  - Opcode JMP_OPC or JZ_OPC -> OPER.
  - Otherwise -> EXEC.
- EXEC: REG_WE=1 iff opcode is in 1..ALU_OPC_MAX. Opcodes 0 and ALU_OPC_MAX+1..7, plus unlisted 8..E, execute as NOP. RETIRED increments. Next state FETCH.
- OPER with STALL=1: no strobes; stay. INSTR holds the operand byte at the PC.
- OPER with STALL=0, jump taken (JMP, or JZ with ZF=1): LOAD=1, LOAD_ADDR=INSTR, INC=0.
- OPER with STALL=0, JZ not taken: INC=1 to skip the operand, LOAD=0.
- OPER with STALL=0, either case: RETIRED increments; next state FETCH.
- HALT: HALTED=1, no strobes, START ignored. Exit only via RST.
- Invariants:
  - INC and LOAD are never 1 together.
  - LOAD_ADDR=8'h00 whenever LOAD=0.
  - Exactly one IR_WE per instruction.
- Latency with STALL=0:
  - ALU/NOP instruction: 3 cycles (FETCH, DECODE, EXEC).
  - Jump: 3 cycles (FETCH, DECODE, OPER).
  - HLT: 2 cycles to reach HALT; HLT is not counted in RETIRED.
- RETIRED wraps 8'hFF -> 8'h00 and never saturates.
- PC wrap (INC at PC=8'hFF) is the PC's concern; the sequencer just issues INC.

Test Plan:
- Reset/idle: RST=1 two cycles, START=0 -> STATE=0 and all outputs 0. Assert RST mid-OPER -> STATE=0 and RETIRED=0 next edge.
- ALU op: START pulse, INSTR=8'h35, STALL=0 -> IR_WE+INC in FETCH, REG_WE=1 exactly in EXEC 2 cycles later, RETIRED=1, back in FETCH on cycle 4.
- Jump: INSTR=8'h80 then operand 8'h42 -> LOAD=1 and LOAD_ADDR=8'h42 in OPER, INC=0 that cycle. JZ 8'h90 / 8'h10 with ZF=0 -> INC=1, LOAD=0.
- Stall: STALL=1 for 3 cycles in FETCH and 2 in OPER -> no strobes during stall, state held, single IR_WE per instruction, final LOAD_ADDR correct.
- Halt: INSTR=8'hF0 -> HALTED=1 after DECODE. START toggled for 10 cycles -> stays HALT, RETIRED unchanged. RST -> IDLE.
- Counter wrap: 256 NOP instructions (8'h00) -> RETIRED 8'hFF -> 8'h00. INC and LOAD never both 1 over the whole run.
